// File: rtl/debug_overlay_pkg.sv
// Shared constants for the debug hex overlay: cell geometry, the blank glyph code and the 8x8 hex font.
package debug_overlay_pkg;

    localparam int CELL_W_DOTS   = 16;
    localparam int CELL_H        = 8;
    localparam int CHARS_PER_ROW = 6;
    localparam int BOX_W_DOTS    = CELL_W_DOTS * CHARS_PER_ROW;

    // Glyph codes are {blank, nibble}; any code with bit 4 set renders empty.
    localparam int          CODE_W = 5;
    localparam logic [4:0]  BLANK  = 5'h10;

    // 16 glyphs x 8 rows, bit 7 is the leftmost pixel.
    localparam logic [7:0] FONT_HEX [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
        '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
    };

endpackage

// File: rtl/debug_hex_font_rom.sv
// Hex font lookup (glyph code, glyph row) -> pixel byte; 1-cycle registered, no backpressure.
// Blank codes return an all-zero byte.
module debug_hex_font_rom
    import debug_overlay_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic [2:0]        gy,
    output logic [7:0]        font_byte
);

    logic [7:0] byte_d;
    logic [7:0] byte_q;

    always_comb begin
        byte_d = 8'h00;
        if (!code[CODE_W-1]) begin
            byte_d = FONT_HEX[code[3:0]][gy];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= 8'h00;
        end else begin
            byte_q <= byte_d;
        end
    end

    assign font_byte = byte_q;

endmodule

// File: rtl/debug_hex_overlay.sv
// Renders NUM_ENTRIES debug words as hex text over live VGA video; 3-cycle latency, free-running, no backpressure.
// Macro DEBUG_OVERLAY_BLEND_EN: in-window background shows dimmed video instead of opaque black.
module debug_hex_overlay
    import debug_overlay_pkg::*;
#(
    parameter int         NUM_ENTRIES = 8,
    parameter int         ORIGIN_X    = 336,
    parameter int         ORIGIN_Y    = 53,
    parameter logic [8:0] FG_RGB      = 9'h1FF
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic [19:0] dot,
    input  logic [19:0] y_count_in,
    input  logic [23:0] debug_ramAddress,
    input  logic [15:0] debug_ramData,
    input  logic        debug_flagReadOK,
    input  logic        overlay_en,
    input  logic [2:0]  r_in,
    input  logic [2:0]  g_in,
    input  logic [2:0]  b_in,
    output logic [2:0]  r_out,
    output logic [2:0]  g_out,
    output logic [2:0]  b_out
);

    localparam logic [19:0] X_LO = 20'(ORIGIN_X);
    localparam logic [19:0] X_HI = 20'(ORIGIN_X + BOX_W_DOTS);
    localparam logic [19:0] Y_LO = 20'(ORIGIN_Y);
    localparam logic [19:0] Y_HI = 20'(ORIGIN_Y + CELL_H * NUM_ENTRIES);

    logic [15:0] shadow_d  [NUM_ENTRIES];
    logic [15:0] shadow_q  [NUM_ENTRIES];
    logic [15:0] display_d [NUM_ENTRIES];
    logic [15:0] display_q [NUM_ENTRIES];

    // Register file: writes land in shadow; display copies shadow once per frame.
    logic wr_ok;
    logic snap;

    always_comb begin
        wr_ok = debug_flagReadOK && (debug_ramAddress < 24'(NUM_ENTRIES));
        snap  = (y_count_in == 20'd0) && (dot == 20'd0);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            shadow_d[i]  = shadow_q[i];
            display_d[i] = display_q[i];
            if (wr_ok && (debug_ramAddress == 24'(i))) begin
                shadow_d[i] = debug_ramData;
            end
            if (snap) begin
                display_d[i] = shadow_q[i];
            end
        end
    end

    // S1: window test and cell/glyph coordinates.
    logic       in_win_d, in_win_q;
    logic [2:0] col_d, col_q;
    logic [2:0] gx_d, gx_q;
    logic [3:0] row_d, row_q;
    logic [2:0] gy_d, gy_q;
    logic       en1_d, en1_q;
    logic [8:0] vid1_d, vid1_q;
    logic [6:0] rel_x;
    logic [6:0] rel_y;

    always_comb begin
        in_win_d = (dot >= X_LO) && (dot < X_HI) &&
                   (y_count_in >= Y_LO) && (y_count_in < Y_HI);
        rel_x    = 7'(dot - X_LO);
        rel_y    = 7'(y_count_in - Y_LO);
        col_d    = rel_x[6:4];
        gx_d     = rel_x[3:1];
        row_d    = rel_y[6:3];
        gy_d     = rel_y[2:0];
        en1_d    = overlay_en;
        vid1_d   = {r_in, g_in, b_in};
    end

    // S2: pick the glyph code for this cell; the font ROM registers the row byte.
    logic              win2_d, win2_q;
    logic [2:0]        gx2_d, gx2_q;
    logic              en2_d, en2_q;
    logic [8:0]        vid2_d, vid2_q;
    logic [15:0]       word;
    logic [CODE_W-1:0] code;
    logic [7:0]        font_byte;

    always_comb begin
        word = 16'h0000;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (row_q == 4'(i)) begin
                word = display_q[i];
            end
        end
        case (col_q)
            3'd0:    code = {1'b0, row_q};
            3'd2:    code = {1'b0, word[15:12]};
            3'd3:    code = {1'b0, word[11:8]};
            3'd4:    code = {1'b0, word[7:4]};
            3'd5:    code = {1'b0, word[3:0]};
            default: code = BLANK;
        endcase
        win2_d = in_win_q;
        gx2_d  = gx_q;
        en2_d  = en1_q;
        vid2_d = vid1_q;
    end

    debug_hex_font_rom u_font (
        .clk       (CLOCK_50),
        .rst_n     (RST_N),
        .code      (code),
        .gy        (gy_q),
        .font_byte (font_byte)
    );

    // S3: glyph bit selects foreground, background or pass-through.
    logic       glyph_bit;
    logic [8:0] bg_rgb;
    logic [8:0] out_d, out_q;

    always_comb begin
        glyph_bit = font_byte[3'd7 - gx2_q];
`ifdef DEBUG_OVERLAY_BLEND_EN
        bg_rgb = {1'b0, vid2_q[8:7], 1'b0, vid2_q[5:4], 1'b0, vid2_q[2:1]};
`else
        bg_rgb = 9'h000;
`endif
        if (!en2_q || !win2_q) begin
            out_d = vid2_q;
        end else if (glyph_bit) begin
            out_d = FG_RGB;
        end else begin
            out_d = bg_rgb;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i]  <= 16'h0000;
                display_q[i] <= 16'h0000;
            end
            in_win_q <= 1'b0;
            col_q    <= 3'd0;
            gx_q     <= 3'd0;
            row_q    <= 4'd0;
            gy_q     <= 3'd0;
            en1_q    <= 1'b0;
            vid1_q   <= 9'h000;
            win2_q   <= 1'b0;
            gx2_q    <= 3'd0;
            en2_q    <= 1'b0;
            vid2_q   <= 9'h000;
            out_q    <= 9'h000;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i]  <= shadow_d[i];
                display_q[i] <= display_d[i];
            end
            in_win_q <= in_win_d;
            col_q    <= col_d;
            gx_q     <= gx_d;
            row_q    <= row_d;
            gy_q     <= gy_d;
            en1_q    <= en1_d;
            vid1_q   <= vid1_d;
            win2_q   <= win2_d;
            gx2_q    <= gx2_d;
            en2_q    <= en2_d;
            vid2_q   <= vid2_d;
            out_q    <= out_d;
        end
    end

    assign r_out = out_q[8:6];
    assign g_out = out_q[5:3];
    assign b_out = out_q[2:0];

endmodule

// File: tb/tb_debug_hex_overlay.sv
// Randomized bench for debug_hex_overlay against a pixel-level model of the overlay rules.
module tb_debug_hex_overlay;

    localparam int         NE = 8;
    localparam int         OX = 336;
    localparam int         OY = 53;
    localparam logic [8:0] FG = 9'h1FF;

    logic        CLOCK_50 = 1'b0;
    logic        RST_N = 1'b0;
    logic [19:0] dot = '0;
    logic [19:0] y_count_in = '0;
    logic [23:0] debug_ramAddress = '0;
    logic [15:0] debug_ramData = '0;
    logic        debug_flagReadOK = 1'b0;
    logic        overlay_en = 1'b0;
    logic [2:0]  r_in = '0, g_in = '0, b_in = '0;
    logic [2:0]  r_out, g_out, b_out;

    always #10 CLOCK_50 = ~CLOCK_50;

    debug_hex_overlay #(
        .NUM_ENTRIES (NE),
        .ORIGIN_X    (OX),
        .ORIGIN_Y    (OY),
        .FG_RGB      (FG)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .RST_N            (RST_N),
        .dot              (dot),
        .y_count_in       (y_count_in),
        .debug_ramAddress (debug_ramAddress),
        .debug_ramData    (debug_ramData),
        .debug_flagReadOK (debug_flagReadOK),
        .overlay_en       (overlay_en),
        .r_in             (r_in),
        .g_in             (g_in),
        .b_in             (b_in),
        .r_out            (r_out),
        .g_out            (g_out),
        .b_out            (b_out)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] font [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
        '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
    };

    logic [15:0] m_shadow [NE];
    logic [15:0] m_disp   [NE];

    typedef struct {
        logic [8:0] exp;
        int         d;
        int         y;
    } exp_t;
    exp_t pend[$];

    function automatic logic [8:0] model_pix(int d, int y, bit en, logic [2:0] r, logic [2:0] g, logic [2:0] b);
        int cx, px, ry, py, nib;
        logic [7:0] glyph;
        logic [8:0] bg;
`ifdef DEBUG_OVERLAY_BLEND_EN
        bg = {r >> 1, g >> 1, b >> 1};
`else
        bg = 9'h000;
`endif
        if (!en || d < OX || d >= OX + 96 || y < OY || y >= OY + 8 * NE) return {r, g, b};
        cx = (d - OX) / 16;
        px = ((d - OX) % 16) / 2;
        ry = (y - OY) / 8;
        py = (y - OY) % 8;
        if (cx == 1) begin
            glyph = 8'h00;
        end else begin
            nib   = (cx == 0) ? ry : int'((m_disp[ry] >> (4 * (5 - cx))) & 16'hF);
            glyph = font[nib][py];
        end
        return glyph[7 - px] ? FG : bg;
    endfunction

    // One clock: check the output due now, then apply a new input vector.
    task automatic step(int d, int y, bit en, logic [2:0] r, logic [2:0] g, logic [2:0] b,
                        bit wr, logic [23:0] addr, logic [15:0] data);
        exp_t e;
        @(negedge CLOCK_50);
        if (pend.size() >= 3) begin
            e = pend.pop_front();
            vectors++;
            if ({r_out, g_out, b_out} !== e.exp) begin
                miscompares++;
                $display("FAIL pix dot=%0d y=%0d got=%h exp=%h", e.d, e.y, {r_out, g_out, b_out}, e.exp);
            end
        end
        dot              = 20'(d);
        y_count_in       = 20'(y);
        overlay_en       = en;
        r_in             = r;
        g_in             = g;
        b_in             = b;
        debug_flagReadOK = wr;
        debug_ramAddress = addr;
        debug_ramData    = data;
        if (d == 0 && y == 0) begin
            for (int i = 0; i < NE; i++) m_disp[i] = m_shadow[i];
        end
        e.exp = model_pix(d, y, en, r, g, b);
        e.d   = d;
        e.y   = y;
        pend.push_back(e);
        if (wr && addr < 24'(NE)) m_shadow[int'(addr)] = data;
    endtask

    task automatic pix(int d, int y, bit en);
        step(d, y, en, 3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 24'd0, 16'd0);
    endtask

    task automatic scan_rows(int first_row, int nrows);
        for (int y = OY + 8 * first_row; y < OY + 8 * (first_row + nrows); y++)
            for (int d = OX; d < OX + 96; d++) pix(d, y, 1'b1);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) pix(800, 300, 1'b0);
    endtask

    task automatic do_reset(int ncyc);
        @(negedge CLOCK_50);
        RST_N = 1'b0;
        debug_flagReadOK = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            r_in = 3'($urandom); g_in = 3'($urandom); b_in = 3'($urandom);
            overlay_en = 1'b0;
            @(negedge CLOCK_50);
            vectors++;
            if ({r_out, g_out, b_out} !== 9'h000) begin
                miscompares++;
                $display("FAIL reset_out got=%h exp=000", {r_out, g_out, b_out});
            end
        end
        r_in = '0; g_in = '0; b_in = '0;
        overlay_en = 1'b0;
        dot = 20'd800;
        y_count_in = 20'd300;
        RST_N = 1'b1;
        for (int i = 0; i < NE; i++) begin
            m_shadow[i] = 16'h0000;
            m_disp[i]   = 16'h0000;
        end
        pend.delete();
        for (int i = 0; i < 3; i++) pend.push_back('{exp: 9'h000, d: -1, y: -1});
    endtask

    task automatic test_reset();
        do_reset(4);
    endtask

    task automatic test_passthrough();
        step(700, 100, 1'b0, 3'd5, 3'd2, 3'd7, 1'b0, 24'd0, 16'd0);
        for (int i = 0; i < 40; i++)
            pix($urandom_range(OX - 16, OX + 112), $urandom_range(OY - 4, OY + 70), 1'b0);
        flush();
    endtask

    task automatic test_write_snapshot();
        step(800, 200, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'd2, 16'hA5C3);
        scan_rows(2, 1);
        pix(0, 0, 1'b0);
        scan_rows(2, 1);
        flush();
    endtask

    task automatic test_bad_addr();
        step(900, 400, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'd9, 16'hFFFF);
        step(900, 401, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'h100002, 16'hBEEF);
        step(900, 402, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'h000010, 16'h7777);
        for (int f = 0; f < 2; f++) begin
            pix(0, 0, 1'b0);
            scan_rows(0, NE);
        end
        flush();
    endtask

    task automatic test_snap_write();
        step(0, 0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'd0, 16'h1234);
        scan_rows(0, 1);
        pix(0, 0, 1'b0);
        scan_rows(0, 1);
        flush();
    endtask

    task automatic test_edges();
        for (int k = 0; k < 4; k++) begin
            pix(OX - 1, OY + 2, 1'b1);
            pix(OX + 96, OY + 2, 1'b1);
            pix(OX + 95, OY + 2, 1'b1);
            pix(OX, OY - 1, 1'b1);
            pix(OX, OY + 8 * NE, 1'b1);
            pix(OX, OY + 8 * NE - 1, 1'b1);
            pix(OX, OY, 1'b1);
            pix(0, OY, 1'b1);
        end
        step(OX + 22, OY, 1'b1, 3'd6, 3'd7, 3'd1, 1'b0, 24'd0, 16'd0);
        flush();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            int d, y;
            bit wr;
            logic [23:0] addr;
            d = $urandom_range(OX - 8, OX + 104);
            y = $urandom_range(OY - 4, OY + 8 * NE + 4);
            if ($urandom_range(0, 199) == 0) begin
                d = 0;
                y = 0;
            end
            wr = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 15));
            step(d, y, ($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
                 wr, addr, 16'($urandom));
        end
        flush();
    endtask

    task automatic test_mid_reset();
        step(500, 150, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 24'd5, 16'hFEDC);
        pix(0, 0, 1'b0);
        pix(OX + 40, OY + 43, 1'b1);
        flush();
        do_reset(2);
        scan_rows(0, NE);
        flush();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_write_snapshot();
        test_bad_addr();
        test_snap_write();
        test_edges();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
